// File: rtl/multicycle_ctrl_if.sv
// Shared memory port between the multicycle controller (master) and memory (slave).
// Handshake: mem_req rises with mem_we/iord valid and holds them steady until the cycle mem_ready=1, which completes the transfer.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for an RV64I-subset multicycle datapath sharing one memory port
// between fetch and data access, with a memory watchdog and a retired counter.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                zero,
  multicycle_ctrl_if.master   mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_src,
  output logic                old_pc_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          dbg_state,
  output logic                dbg_br_taken
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, HALT
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               in_mem;
  logic               timeout;
  logic               op_legal;

  assign in_mem   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign timeout  = in_mem && !mem.mem_ready && (wait_q == WAIT_MAX);
  assign op_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                    (opcode == OP_ST) || (opcode == OP_BR);

  // The wait counter is zero in every non-memory state, so entering a memory state starts it from zero.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    bus_err_d = bus_err_q;
    wait_d    = '0;
    if (in_mem && !mem.mem_ready) wait_d = wait_q + WAIT_W'(1);
    case (state_q)
      FETCH:    if (mem.mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:         state_d = EXEC_R;
          OP_I:         state_d = EXEC_I;
          OP_LD, OP_ST: state_d = MEM_ADDR;
          OP_BR:        state_d = BRANCH;
          default:      state_d = FETCH;
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      WB_ALU, WB_MEM, BRANCH: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = FETCH;
      end
      MEM_ADDR: state_d = (opcode == OP_LD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem.mem_ready) state_d = WB_MEM;
      MEM_WR: begin
        if (mem.mem_ready) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      default:  state_d = HALT;
    endcase
    if (timeout) begin
      state_d   = HALT;
      bus_err_d = 1'b1;
      wait_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  // Decoded from the state register; gated by reset so the request drops the moment reset rises.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    old_pc_write  = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    dbg_br_taken  = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem.mem_req  = 1'b1;
          old_pc_write = 1'b1;
          alu_src_b    = 2'b01;
          ir_write     = mem.mem_ready;
          pc_write     = mem.mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b10;
          illegal   = !op_legal;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
        end
        WB_ALU:   reg_write = 1'b1;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.iord    = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          dbg_br_taken  = zero;
        end
        default: ;
      endcase
    end
  end

  assign bus_err   = bus_err_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level model builds the expected per-cycle
// output trace, a negedge compare process checks it, plus literal spot checks.
module tb_multicycle_ctrl;
  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, old_pc_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write, mem_to_reg, illegal, bus_err, br_taken;
    logic [TB_CNT_W-1:0] retired;
  } out_t;
  localparam int OW = $bits(out_t);

  typedef enum {P_RST, P_FETCH, P_DECODE, P_EXR, P_EXI, P_WBA, P_ADDR, P_RD, P_WBM, P_WR, P_BR, P_HALT} ph_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = '0;
  logic zero = 1'b0;
  logic ir_write, pc_write, pc_write_cond, pc_src, old_pc_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic reg_write, mem_to_reg, illegal, bus_err, dbg_br_taken;
  logic [TB_CNT_W-1:0] retired;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  initial bus.mem_ready = 1'b0;

  multicycle_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem(bus.master),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .old_pc_write(old_pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err),
    .retired(retired), .dbg_state(dbg_state), .dbg_br_taken(dbg_br_taken)
  );

  logic [OW-1:0] act;
  assign act = {bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_write_cond, pc_src,
                old_pc_write, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal,
                bus_err, dbg_br_taken, retired};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      n_cyc++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL trace cycle %0d: got %h expected %h", n_cyc, act, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [TB_CNT_W-1:0] m_retired = '0;
  logic m_bus_err = 1'b0;

  function automatic logic is_legal(input logic [6:0] op);
    logic [6:0] legal[5];
    legal = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic out_t expect_out(input ph_t ph, input logic rdy, input logic [6:0] op, input logic z);
    out_t e;
    e = '0;
    e.bus_err = m_bus_err;
    e.retired = m_retired;
    case (ph)
      P_RST:    e = '0;
      P_FETCH:  begin e.mem_req = 1; e.old_pc_write = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      P_DECODE: begin e.alu_src_b = 2'b10; e.illegal = !is_legal(op); end
      P_EXR:    begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      P_EXI:    begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
      P_WBA:    e.reg_write = 1;
      P_ADDR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      P_RD:     begin e.mem_req = 1; e.iord = 1; end
      P_WBM:    begin e.reg_write = 1; e.mem_to_reg = 1; end
      P_WR:     begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
      P_BR:     begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_src = 1; e.br_taken = z; end
      default:  begin e = '0; e.bus_err = 1'b1; e.retired = m_retired; end
    endcase
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one cycle at posedge+1, records its expected outputs, returns at next posedge+1.
  task automatic cyc(input ph_t ph, input logic rdy, input logic [6:0] op);
    logic z;
    z = rnd();
    reset = (ph == P_RST);
    bus.mem_ready = rdy;
    opcode = op;
    zero = z;
    exp_q.push_back(expect_out(ph, rdy, op, z));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    m_retired = '0;
    m_bus_err = 1'b0;
    for (int i = 0; i < n; i++) cyc(P_RST, rnd(), 7'($urandom_range(0, 127)));
  endtask

  // A request may sit unanswered for at most TB_TIMEOUT cycles; one more unanswered cycle is a bus error.
  task automatic mem_phase(input ph_t ph, input int w, input logic [6:0] op, output logic ok);
    ok = 1'b0;
    for (int k = 0; k <= TB_TIMEOUT; k++) begin
      if (k == w) begin
        cyc(ph, 1'b1, op);
        ok = 1'b1;
        break;
      end
      cyc(ph, 1'b0, op);
    end
    if (!ok) m_bus_err = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int dw);
    logic ok;
    mem_phase(P_FETCH, fw, op, ok);
    if (!ok) return;
    cyc(P_DECODE, rnd(), op);
    case (op)
      OP_R:  begin cyc(P_EXR, rnd(), op); cyc(P_WBA, rnd(), op); m_retired++; end
      OP_I:  begin cyc(P_EXI, rnd(), op); cyc(P_WBA, rnd(), op); m_retired++; end
      OP_LD: begin
        cyc(P_ADDR, rnd(), op);
        mem_phase(P_RD, dw, op, ok);
        if (ok) begin cyc(P_WBM, rnd(), op); m_retired++; end
      end
      OP_ST: begin
        cyc(P_ADDR, rnd(), op);
        mem_phase(P_WR, dw, op, ok);
        if (ok) m_retired++;
      end
      OP_BR: begin cyc(P_BR, rnd(), op); m_retired++; end
      default: ;
    endcase
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops[7];
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, 7'h7f, 7'h00};
    ops[6] = 7'($urandom_range(0, 127));
    return ops[$urandom_range(0, 6)];
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] halt_state;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(OP_R, 0, 0);
    check("r_type_retired", 32'(retired), 32'd1);
    run_instr(OP_LD, 0, 3);
    check("load_retired", 32'(retired), 32'd2);
    run_instr(OP_ST, 1, 1);
    run_instr(OP_BR, 0, 0);
    run_instr(OP_I, 2, 0);
    check("mixed_retired", 32'(retired), 32'd5);
    run_instr(7'h7f, 0, 0);
    check("illegal_retired", 32'(retired), 32'd5);
    run_instr(OP_R, TB_TIMEOUT, 0);
    check("fetch_at_limit_no_err", 32'(bus_err), 32'd0);
    run_instr(OP_LD, 0, TB_TIMEOUT);
    run_instr(OP_ST, 0, TB_TIMEOUT);
    check("data_at_limit_retired", 32'(retired), 32'd8);

    for (int i = 0; i < 80; i++)
      run_instr(pick_op(), $urandom_range(0, TB_TIMEOUT), $urandom_range(0, TB_TIMEOUT));

    // abandon a load while its data request is still waiting
    run_instr(OP_R, 0, 0);
    begin
      logic ok;
      mem_phase(P_FETCH, 0, OP_LD, ok);
      cyc(P_DECODE, rnd(), OP_LD);
      cyc(P_ADDR, rnd(), OP_LD);
      cyc(P_RD, 1'b0, OP_LD);
      cyc(P_RD, 1'b0, OP_LD);
    end
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    do_reset(2);

    for (int i = 0; i < 15; i++) run_instr(OP_R, 0, 0);
    check("retired_max", 32'(retired), 32'd15);
    run_instr(OP_BR, 0, 0);
    check("retired_wrap", 32'(retired), 32'd0);

    run_instr(OP_R, TB_TIMEOUT + 1, 0);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    halt_state = dbg_state;
    for (int i = 0; i < 4; i++) cyc(P_HALT, rnd(), pick_op());
    check("halt_held", 32'(dbg_state), 32'(halt_state));
    check("halt_bus_err_sticky", 32'(bus_err), 32'd1);
    do_reset(2);
    check("reset_clears_bus_err", 32'(bus_err), 32'd0);
    run_instr(OP_I, 1, 0);
    check("post_reset_retired", 32'(retired), 32'd1);

    @(negedge clk);
    check("trace_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
